// File: rtl/button_event_fsm_if.sv
// Button event bus: the debounced level in, the event pulses and held status out.
// slave  = the event FSM (consumes btn_in, drives events)
// master = the downstream consumer / stimulus side
interface button_event_fsm_if;
  logic btn_in;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic held;
  logic long_held;

  modport slave (
    input  btn_in,
    output press_pulse, release_pulse, long_pulse, repeat_pulse, held, long_held
  );

  modport master (
    output btn_in,
    input  press_pulse, release_pulse, long_pulse, repeat_pulse, held, long_held
  );
endinterface

// File: rtl/button_event_fsm.sv
// button_event_fsm: turns a debounced, clk-synchronous button level into
// single-cycle press / release / long-press / auto-repeat events plus
// held-level status. All outputs are registered at the edge that samples btn_in.
// Optional feature macro: BTN_AUTO_REPEAT_EN (auto-repeat pulses while in HOLD).
module button_event_fsm #(
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned CNT_W         = 26
) (
  input  logic               clk,
  input  logic               rst_n,
  button_event_fsm_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int unsigned LP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam logic [CNT_W-1:0] LP_HOLD  = CNT_W'(HOLD_CYCLES);
  // Saturation guard: the counter is always reloaded before this, it just
  // guarantees no wrap even if the terminal compare were ever missed.
  localparam logic [CNT_W-1:0] LP_SAT   = CNT_W'(LP_MAX);
  localparam logic [CNT_W-1:0] LP_ONE   = CNT_W'(1);
`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] LP_REPEAT = CNT_W'(REPEAT_CYCLES);
`endif

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;
  logic             r_release;
  logic             r_long;
  logic             r_held;
  logic             r_long_held;
`ifdef BTN_AUTO_REPEAT_EN
  logic             r_repeat;
`endif

  // Event FSM: state, counter and all registered outputs in one block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_long      <= 1'b0;
      r_held      <= 1'b0;
      r_long_held <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      r_repeat    <= 1'b0;
`endif
    end else begin
      // Pulses default low; each branch raises at most one of them.
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      r_repeat  <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (bus.btn_in) begin
            r_press <= 1'b1;
            r_held  <= 1'b1;
            r_cnt   <= LP_ONE;
            r_state <= PRESS;
          end
        end
        PRESS: begin
          if (!bus.btn_in) begin
            r_release <= 1'b1;
            r_held    <= 1'b0;
            r_cnt     <= '0;
            r_state   <= IDLE;
          end else if (r_cnt == LP_HOLD) begin
            r_long      <= 1'b1;
            r_long_held <= 1'b1;
            r_cnt       <= LP_ONE;
            r_state     <= HOLD;
          end else if (r_cnt != LP_SAT) begin
            r_cnt <= r_cnt + LP_ONE;
          end
        end
        HOLD: begin
          // Release always wins over a coincident repeat.
          if (!bus.btn_in) begin
            r_release   <= 1'b1;
            r_held      <= 1'b0;
            r_long_held <= 1'b0;
            r_cnt       <= '0;
            r_state     <= IDLE;
          end
`ifdef BTN_AUTO_REPEAT_EN
          else if (r_cnt == LP_REPEAT) begin
            r_repeat <= 1'b1;
            r_cnt    <= LP_ONE;
          end else if (r_cnt != LP_SAT) begin
            r_cnt <= r_cnt + LP_ONE;
          end
`endif
        end
        default: begin
          r_state     <= IDLE;
          r_cnt       <= '0;
          r_held      <= 1'b0;
          r_long_held <= 1'b0;
        end
      endcase
    end
  end

  assign bus.press_pulse   = r_press;
  assign bus.release_pulse = r_release;
  assign bus.long_pulse    = r_long;
  assign bus.held          = r_held;
  assign bus.long_held     = r_long_held;
`ifdef BTN_AUTO_REPEAT_EN
  assign bus.repeat_pulse  = r_repeat;
`else
  assign bus.repeat_pulse  = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_fsm.sv
// Directed bench for button_event_fsm with HOLD_CYCLES=8, REPEAT_CYCLES=4.
// Expected outputs come from a closed-form per-edge model: for a press whose
// first sampled-high edge is index 0 and which stays high for h edges,
// the outputs at edge e are derived from e and h only.
module tb_button_event_fsm;
  localparam int HOLD = 8;
  localparam int REP  = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  button_event_fsm_if ifc ();

  button_event_fsm #(
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REP),
    .CNT_W         (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {press, release, long, repeat, held, long_held}
  function automatic logic [5:0] outs();
    return {ifc.press_pulse, ifc.release_pulse, ifc.long_pulse,
            ifc.repeat_pulse, ifc.held, ifc.long_held};
  endfunction

  function automatic logic [5:0] exp_at(input int e, input int h);
    logic p, r, l, rp, hd, lh;
    p = 0; r = 0; l = 0; rp = 0; hd = 0; lh = 0;
    if (e < h) begin
      p  = (e == 0);
      hd = 1'b1;
      l  = (e == HOLD);
      lh = (e >= HOLD);
`ifdef BTN_AUTO_REPEAT_EN
      rp = (e > HOLD) && (((e - HOLD) % REP) == 0);
`endif
    end else if (e == h) begin
      r = 1'b1;
    end
    return {p, r, l, rp, hd, lh};
  endfunction

  // Drive btn_in, take one rising edge, land 1 time unit after it.
  task automatic step(input logic b);
    ifc.btn_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] exp;
    rst_n = 1'b1;
    ifc.btn_in = 1'b0;
    #2;
    rst_n = 1'b0;
    ifc.btn_in = 1'b1;
    #1;
    checks++;
    if (outs() !== 6'b0) begin
      errors++;
      $display("FAIL reset_async: got %b want %b", outs(), 6'b0);
    end
    @(posedge clk); #1;
    checks++;
    if (outs() !== 6'b0) begin
      errors++;
      $display("FAIL reset_held_low: got %b want %b", outs(), 6'b0);
    end
    rst_n = 1'b1;
    for (int e = 0; e <= 2; e++) begin
      step(e < 1);
      exp = exp_at(e, 1);
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL reset_first_press edge %0d: got %b want %b", e, outs(), exp);
      end
    end
  endtask

  task automatic test_short_press();
    logic [5:0] exp;
    for (int e = 0; e <= 5; e++) begin
      step(e < 3);
      exp = exp_at(e, 3);
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL short_press edge %0d: got %b want %b", e, outs(), exp);
      end
    end
  endtask

  task automatic test_threshold();
    logic [5:0] exp;
    // One edge short of the threshold: no long_pulse.
    for (int e = 0; e <= 9; e++) begin
      step(e < 8);
      exp = exp_at(e, 8);
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL threshold_minus1 edge %0d: got %b want %b", e, outs(), exp);
      end
    end
    // Exactly reaches the threshold: long at edge 8, release at 9.
    for (int e = 0; e <= 10; e++) begin
      step(e < 9);
      exp = exp_at(e, 9);
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL threshold_exact edge %0d: got %b want %b", e, outs(), exp);
      end
    end
  endtask

  task automatic test_auto_repeat();
    logic [5:0] exp;
    for (int e = 0; e <= 22; e++) begin
      step(e < 20);
      exp = exp_at(e, 20);
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL auto_repeat edge %0d: got %b want %b", e, outs(), exp);
      end
    end
  endtask

  task automatic test_glitch();
    logic [5:0] exp;
    for (int e = 0; e <= 3; e++) begin
      step(e < 1);
      exp = exp_at(e, 1);
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL glitch edge %0d: got %b want %b", e, outs(), exp);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [5:0] exp;
    for (int e = 0; e <= 10; e++) begin
      step(1'b1);
      exp = exp_at(e, 100);
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL mid_hold_pre edge %0d: got %b want %b", e, outs(), exp);
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 6'b0) begin
      errors++;
      $display("FAIL mid_hold_async_reset: got %b want %b", outs(), 6'b0);
    end
    @(posedge clk); #1;
    checks++;
    if (outs() !== 6'b0) begin
      errors++;
      $display("FAIL mid_hold_no_release: got %b want %b", outs(), 6'b0);
    end
    rst_n = 1'b1;
    for (int e = 0; e <= 11; e++) begin
      step(e < 9);
      exp = exp_at(e, 9);
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL mid_hold_repress edge %0d: got %b want %b", e, outs(), exp);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_short_press();
    test_threshold();
    test_auto_repeat();
    test_glitch();
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
